wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Shares one WISHBONE slave bus (20-bit address, 32-bit data) between NMASTERS
//  bus masters, e.g. the VIO bridge, the PCI bridge and the readout sequencer.
//  Round-robin grant with bus hold while the owner keeps cyc asserted.
//  A watchdog terminates strobes that get no ack/err/rty.
//  Sits between the master bridges and the slave address decoder.
// PARAMETERS
//  NMASTERS   4      number of masters, 2..8
//  ADR_WIDTH  20     address width
//  DAT_WIDTH  32     data width
//  TIMEOUT    1023   strobe cycles without termination before forced err; 0 = watchdog off
// PORTS
//  clk_i       in   1                    system clock
//  rst_n_i     in   1                    synchronous reset, active low
//  m_cyc_i     in   NMASTERS             master cyc, bit k = master k
//  m_stb_i     in   NMASTERS             master stb
//  m_we_i      in   NMASTERS             master we
//  m_adr_i     in   NMASTERS*ADR_WIDTH   master address, master k at [k*ADR_WIDTH +: ADR_WIDTH]
//  m_dat_i     in   NMASTERS*DAT_WIDTH   master write data, same packing
//  m_dat_o     out  DAT_WIDTH            read data, s_dat_i broadcast to all masters
//  m_ack_o     out  NMASTERS             ack to grantee only
//  m_err_o     out  NMASTERS             err to grantee only (slave err or watchdog)
//  m_rty_o     out  NMASTERS             rty to grantee only
//  s_cyc_o     out  1                    slave cyc
//  s_stb_o     out  1                    slave stb
//  s_we_o      out  1                    slave we
//  s_adr_o     out  ADR_WIDTH            slave address
//  s_dat_o     out  DAT_WIDTH            slave write data
//  s_dat_i     in   DAT_WIDTH            slave read data
//  s_ack_i     in   1                    slave ack
//  s_err_i     in   1                    slave err
//  s_rty_i     in   1                    slave rty
//  grant_o     out  NMASTERS             one-hot current owner, registered
//  timeout_o   out  1                    one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - Reset (rst_n_i low at an edge):
//    - State IDLE; grant_o = 0; watchdog count = 0.
//    - Round-robin pointer = NMASTERS-1, so master 0 wins first.
//    - Reset mid-transfer drops the bus immediately; no termination is sent to the master.
//  - IDLE:
//    - All s_* outputs and m_ack/err/rty_o are 0.
//    - If any m_cyc_i is high, grant the first requester after the pointer
//      (wrap modulo NMASTERS), set grant_o, move the pointer to the grantee, go to OWN.
//    - Arbitration latency: 1 clock from cyc to grant_o.
//  - OWN (grantee g):
//    - s_cyc/stb/we/adr/dat_o = master g's inputs, combinational mux.
//    - s_ack/err/rty_i route combinationally to bit g only; other masters see 0.
//    - Masters without grant are stalled: no termination is returned to them.
//    - Grant is held for as long as m_cyc_i[g] stays high (locked multi-strobe use).
//    - When m_cyc_i[g] is low at an edge: go to IDLE, grant_o = 0.
//      This forces at least one idle cycle between owners.
//    - If cyc drops in the same cycle as ack, the ack is still delivered and the grant released.
//    - If cyc drops mid-strobe with no ack, s_stb_o falls with it; any later slave ack is ignored.
//  - Watchdog (TIMEOUT != 0):
//    - The 16-bit count increments on each edge where s_stb_o is high and
//      s_ack_i | s_err_i | s_rty_i is low. It clears on any termination, on stb low,
//      or when leaving OWN.
//    - When count == TIMEOUT: for exactly one cycle m_err_o[g] = 1, timeout_o = 1,
//      and s_stb_o is forced 0. Then the count clears.
//    - The grant is not revoked; the master decides whether to release.
//    - A slave termination arriving in the expiry cycle takes priority:
//      the slave's ack/err/rty is passed through and timeout_o stays 0.
//  - Unused bits of m_ack/err/rty_o are always 0.
//  - At most one m_ack/err/rty_o bit is high per cycle.
// TESTING
//  - Reset, then m_cyc_i=4'b1111 with stb held: grant_o sequence 0001,0010,0100,1000,0001.
//    Each master releases cyc after its ack; there is 1 idle cycle between grants.
//  - M1 locks cyc and issues 3 strobes while M0 requests: M0 is stalled until M1 drops cyc.
//    M1 gets all 3 acks; M0 is granted 2 cycles after the release.
//  - M2 reads 0x00010 and the slave returns 0xDEADBEEF with ack: m_dat_o = 0xDEADBEEF,
//    m_ack_o = 4'b0100, s_adr_o = 0x00010, s_we_o = 0.
//  - TIMEOUT=8, slave never acks: m_err_o[g] and timeout_o pulse once, 8 stb cycles after
//    the strobe starts, with s_stb_o low in that cycle. Ack on the 8th cycle: no timeout_o.
//  - rst_n_i low during M3's strobe: next cycle grant_o=0, s_cyc_o=0.
//    After release, simultaneous M2/M3 requests grant M0... no: grant M2 first (pointer reset).
//  - Slave err and rty: each is routed only to the grantee; grant_o is unchanged afterwards.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Round-robin WISHBONE master arbiter: N masters share one slave bus, grant held while
// the owner keeps cyc high, with a strobe watchdog that forces err on a silent slave.
module wb_master_arbiter #(
  parameter int unsigned NMASTERS  = 4,
  parameter int unsigned ADR_WIDTH = 20,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NMASTERS-1:0]             m_cyc_i,
  input  logic [NMASTERS-1:0]             m_stb_i,
  input  logic [NMASTERS-1:0]             m_we_i,
  input  logic [NMASTERS*ADR_WIDTH-1:0]   m_adr_i,
  input  logic [NMASTERS*DAT_WIDTH-1:0]   m_dat_i,
  output logic [DAT_WIDTH-1:0]            m_dat_o,
  output logic [NMASTERS-1:0]             m_ack_o,
  output logic [NMASTERS-1:0]             m_err_o,
  output logic [NMASTERS-1:0]             m_rty_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADR_WIDTH-1:0]            s_adr_o,
  output logic [DAT_WIDTH-1:0]            s_dat_o,
  input  logic [DAT_WIDTH-1:0]            s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_rty_i,
  output logic [NMASTERS-1:0]             grant_o,
  output logic                            timeout_o
);

  localparam int unsigned PTR_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state, state_d;
  logic [NMASTERS-1:0]  grant_d;
  logic [PTR_W-1:0]     ptr, ptr_d, pick;
  logic                 found;
  int                   idx;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 term, expire, owner_cyc, owner_stb;

  logic [ADR_WIDTH-1:0] adr_arr [NMASTERS];
  logic [DAT_WIDTH-1:0] dat_arr [NMASTERS];

  for (genvar k = 0; k < NMASTERS; k++) begin : g_unpack
    assign adr_arr[k] = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
    assign dat_arr[k] = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
  end

  assign m_dat_o = s_dat_i;

  // The pointer doubles as the grantee index while in OWN.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= PTR_W'(NMASTERS - 1);
      cnt     <= '0;
    end else begin
      state   <= state_d;
      grant_o <= grant_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
    end
  end

  // First requester strictly after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int i = 1; i <= int'(NMASTERS); i++) begin
      idx = (int'(ptr) + i) % int'(NMASTERS);
      if (!found && m_cyc_i[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant_o;
    ptr_d     = ptr;
    cnt_d     = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = 1'b0;
    expire    = 1'b0;
    owner_cyc = m_cyc_i[ptr];
    owner_stb = owner_cyc & m_stb_i[ptr];
    term      = s_ack_i | s_err_i | s_rty_i;

    case (state)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          grant_d = NMASTERS'(1) << pick;
          ptr_d   = pick;
        end
      end
      OWN: begin
        // A real slave termination in the expiry cycle wins over the watchdog.
        expire    = (TIMEOUT != 0) && owner_stb && !term && (cnt == CNT_W'(TIMEOUT));
        s_cyc_o   = owner_cyc;
        s_stb_o   = owner_stb & ~expire;
        s_we_o    = m_we_i[ptr];
        s_adr_o   = adr_arr[ptr];
        s_dat_o   = dat_arr[ptr];
        m_ack_o   = grant_o & {NMASTERS{s_ack_i}};
        m_err_o   = grant_o & {NMASTERS{s_err_i | expire}};
        m_rty_o   = grant_o & {NMASTERS{s_rty_i}};
        timeout_o = expire;
        if ((TIMEOUT != 0) && owner_stb && !term && !expire) cnt_d = cnt + 1'b1;
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Scoreboard bench for wb_master_arbiter: round robin, bus lock, read path,
// watchdog expiry and priority, reset mid-transfer, err/rty routing.
module tb_wb_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, grant;
  logic            s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o, slv_dat;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic            auto_ack, force_ack, force_err, force_rty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]  gq [$];
  logic [DW-1:0] dq [$];

  always #5 clk = ~clk;

  // Slave model: optionally acks the owner's strobe at once; otherwise driven by hand.
  assign s_ack_i = (auto_ack & (|(m_cyc & m_stb & grant))) | force_ack;
  assign s_err_i = force_err;
  assign s_rty_i = force_rty;

  wb_master_arbiter #(.NMASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(slv_dat), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .grant_o(grant), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_stb(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (s_stb_o) ok = 1'b1;
      else @(posedge clk);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic drop_all();
    @(posedge clk); #1;
    m_cyc = '0; m_stb = '0;
    force_ack = 1'b0; force_err = 1'b0; force_rty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0]  dropped, ack_seen, prev_g, cur_exp;
    logic [DW-1:0] exp_d;
    int ngr, gap, acks1, lat, pulses;
    bit done;

    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = 4'b1011;
    m_adr = {20'hAAAAA, 20'h33333, 20'h22222, 20'h11111};
    m_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    slv_dat = 32'h0; auto_ack = 1'b0; force_ack = 1'b0; force_err = 1'b0; force_rty = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    check("rst_timeout", 64'(timeout_o), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin with all four requesting
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    m_cyc = 4'hf; m_stb = 4'hf; auto_ack = 1'b1;
    dropped = '0; prev_g = '0; cur_exp = '0; ngr = 0; gap = 0;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      @(negedge clk);
      ack_seen = m_ack_o;
      if (grant != '0 && grant != prev_g) begin
        cur_exp = gq.pop_front();
        check("rr_grant", 64'(grant), 64'(cur_exp));
        if (ngr > 0) check("rr_idle_gap", 64'(gap), 64'd1);
        ngr++; gap = 0;
      end else if (grant == '0 && ngr > 0) gap++;
      if (ack_seen != '0) check("rr_ack_owner", 64'(ack_seen), 64'(cur_exp));
      prev_g = grant;
      @(posedge clk); #1;
      if (ngr == 5) begin
        m_cyc = '0; m_stb = '0;
      end else begin
        m_cyc = m_cyc | dropped; m_stb = m_stb | dropped;
        dropped = ack_seen;
        m_cyc = m_cyc & ~ack_seen; m_stb = m_stb & ~ack_seen;
      end
    end
    check("rr_all_grants", 64'(ngr), 64'd5);
    check("rr_queue_empty", 64'(gq.size()), 64'd0);
    drop_all();

    // M1 locks the bus for 3 strobes while M0 waits
    m_cyc = 4'b0011; m_stb = 4'b0011; acks1 = 0;
    for (int c = 0; c < 20 && acks1 < 3; c++) begin
      @(negedge clk);
      check("lock_m0_stalled", 64'(m_ack_o[0]), 64'd0);
      if (c > 0) check("lock_grant_held", 64'(grant), 64'b0010);
      if (m_ack_o[1]) acks1++;
      @(posedge clk); #1;
      if (acks1 == 3) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
    end
    check("lock_m1_acks", 64'(acks1), 64'd3);
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (grant == 4'b0001) begin
        lat = c;
        check("lock_m0_ack", 64'(m_ack_o), 64'b0001);
      end
    end
    check("lock_m0_latency", 64'(lat), 64'd2);
    drop_all();

    // M2 read of 0x00010
    m_cyc = 4'b0100; m_stb = 4'b0100;
    m_adr[2*AW +: AW] = 20'h00010;
    slv_dat = 32'hDEADBEEF;
    dq.push_back(32'hDEADBEEF);
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_ack_o != '0) begin
        exp_d = dq.pop_front();
        check("rd_data", 64'(m_dat_o), 64'(exp_d));
        check("rd_ack", 64'(m_ack_o), 64'b0100);
        check("rd_adr", 64'(s_adr_o), 64'h00010);
        check("rd_we", 64'(s_we_o), 64'd0);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("rd_done", 64'(done), 64'd1);
    drop_all();

    // Silent slave: watchdog expires 8 strobe cycles in (M3)
    auto_ack = 1'b0;
    m_cyc = 4'b1000; m_stb = 4'b1000;
    wait_stb("wd_stb_start");
    pulses = 0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (timeout_o) begin
        pulses++;
        check("wd_cycle", 64'(i), 64'd8);
        check("wd_stb_low", 64'(s_stb_o), 64'd0);
        check("wd_err", 64'(m_err_o), 64'b1000);
      end
    end
    check("wd_pulses", 64'(pulses), 64'd1);
    drop_all();

    // Slave ack in the expiry cycle beats the watchdog (M0)
    m_cyc = 4'b0001; m_stb = 4'b0001;
    wait_stb("wdack_stb_start");
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      force_ack = (i == 8);
      @(negedge clk);
      if (timeout_o) pulses++;
      if (i == 8) begin
        check("wdack_ack", 64'(m_ack_o), 64'b0001);
        check("wdack_err", 64'(m_err_o), 64'd0);
      end
    end
    check("wdack_no_timeout", 64'(pulses), 64'd0);
    drop_all();

    // Reset during M3's strobe, then M2/M3 contend
    m_cyc = 4'b1000; m_stb = 4'b1000;
    wait_stb("rst_stb_start");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstx_grant", 64'(grant), 64'h0);
    check("rstx_s_cyc", 64'(s_cyc_o), 64'h0);
    check("rstx_no_term", 64'(m_ack_o | m_err_o | m_rty_o), 64'h0);
    m_cyc = 4'b1100; m_stb = 4'b1100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 5 && !done; c++) begin
      @(negedge clk);
      if (grant != '0) done = 1'b1;
      else @(posedge clk);
    end
    check("rstx_first_grant", 64'(grant), 64'b0100);

    // Slave err and rty go only to M2 and leave the grant alone
    @(posedge clk); #1;
    force_err = 1'b1;
    @(negedge clk);
    check("err_route", 64'(m_err_o), 64'b0100);
    check("err_no_ack", 64'(m_ack_o | m_rty_o), 64'h0);
    @(posedge clk); #1;
    force_err = 1'b0;
    @(negedge clk);
    check("err_grant_kept", 64'(grant), 64'b0100);
    @(posedge clk); #1;
    force_rty = 1'b1;
    @(negedge clk);
    check("rty_route", 64'(m_rty_o), 64'b0100);
    check("rty_no_err", 64'(m_err_o | m_ack_o), 64'h0);
    @(posedge clk); #1;
    force_rty = 1'b0;
    @(negedge clk);
    check("rty_grant_kept", 64'(grant), 64'b0100);
    drop_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
